// File: rtl/microcode_loader_pkg.sv
// Shared definitions for the microcode loader: store geometry, loader state encodings
// and the bytes-per-word helper.
package microcode_loader_pkg;

    localparam int MICRO_WIDTH      = 88;
    localparam int MICRO_ADDR_WIDTH = 9;
    localparam int MICRO_BYTE_WIDTH = 8;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_RECV  = 3'd1,
        LD_WRITE = 3'd2,
        LD_CSUM  = 3'd3,
        LD_DONE  = 3'd4
    } ld_state_e;

    function automatic int bytes_per_word(input int dw, input int bw);
        return (dw + bw - 1) / bw;
    endfunction

endpackage

// File: rtl/microcode_loader_if.sv
// Control, byte-stream and memory-write-port signals of the microcode loader.
// slave = loader side, master = host / boot ROM / memory side.
interface microcode_loader_if
    import microcode_loader_pkg::*;
#(
    parameter int DATA_WIDTH = MICRO_WIDTH,
    parameter int ADDR_WIDTH = MICRO_ADDR_WIDTH,
    parameter int BYTE_WIDTH = MICRO_BYTE_WIDTH
);
    logic                  start;
    logic [ADDR_WIDTH:0]   load_words;
    logic                  in_valid;
    logic [BYTE_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  busy;
    logic                  hold_core;
    logic                  done;
    logic                  error;

    modport slave (
        input  start, load_words, in_valid, in_data,
        output in_ready, mem_we, mem_address, mem_data, busy, hold_core, done, error
    );

    modport master (
        output start, load_words, in_valid, in_data,
        input  in_ready, mem_we, mem_address, mem_data, busy, hold_core, done, error
    );
endinterface

// File: rtl/microcode_loader_assembler.sv
// mc_word_assembler: byte counter plus per-byte lanes building one microword, LSB byte first.
// word_nxt already includes the byte being accepted so the write port can register it directly.
module mc_word_assembler
    import microcode_loader_pkg::*;
#(
    parameter int DATA_WIDTH = MICRO_WIDTH,
    parameter int BYTE_WIDTH = MICRO_BYTE_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] word_nxt
);
    localparam int BPW   = bytes_per_word(DATA_WIDTH, BYTE_WIDTH);
    localparam int CNT_W = $clog2(BPW + 1);

    logic [CNT_W-1:0]                 byte_cnt;
    logic [BPW-1:0][BYTE_WIDTH-1:0]   lanes, lanes_nxt;
    logic [BPW*BYTE_WIDTH-1:0]        flat_nxt;

    assign last = (byte_cnt == CNT_W'(BPW - 1));

    always_comb begin
        lanes_nxt = lanes;
        for (int k = 0; k < BPW; k++) begin
            if (accept && byte_cnt == CNT_W'(k))
                lanes_nxt[k] = byte_in;
        end
    end

    // Bits of the top lane beyond DATA_WIDTH are simply not forwarded.
    assign flat_nxt = lanes_nxt;
    assign word_nxt = flat_nxt[DATA_WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt <= '0;
            lanes    <= '0;
        end else begin
            lanes <= lanes_nxt;
            if (clear)
                byte_cnt <= '0;
            else if (accept)
                byte_cnt <= byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/microcode_loader.sv
// Run-time microcode loader: byte stream -> 88-bit words -> sequential store writes, core held in reset.
// Define MICROCODE_LOADER_CHECKSUM_EN to add the 16-bit checksum trailer and the error flag.
module microcode_loader
    import microcode_loader_pkg::*;
#(
    parameter int DATA_WIDTH = MICRO_WIDTH,
    parameter int ADDR_WIDTH = MICRO_ADDR_WIDTH,
    parameter int BYTE_WIDTH = MICRO_BYTE_WIDTH
) (
    input logic           clock,
    input logic           reset,
    microcode_loader_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    ld_state_e             state;
    logic [ADDR_WIDTH-1:0] addr, last_addr;
    logic [ADDR_WIDTH:0]   words_clamped;
    logic                  mem_we_q, done_q;
    logic [ADDR_WIDTH-1:0] mem_address_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic                  in_ready, accept, asm_accept, asm_clear, asm_last;
    logic [DATA_WIDTH-1:0] asm_word;

    assign in_ready   = (state == LD_RECV) || (state == LD_CSUM);
    assign accept     = bus.in_valid && in_ready;
    assign asm_accept = accept && (state == LD_RECV);
    assign asm_clear  = (state == LD_WRITE) || (state == LD_IDLE && bus.start);

    // The address never wraps: oversize requests load the whole store once.
    assign words_clamped = (bus.load_words > (ADDR_WIDTH + 1)'(DEPTH)) ?
                           (ADDR_WIDTH + 1)'(DEPTH) : bus.load_words;

    mc_word_assembler #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_asm (
        .clock    (clock),
        .reset    (reset),
        .clear    (asm_clear),
        .accept   (asm_accept),
        .byte_in  (bus.in_data),
        .last     (asm_last),
        .word_nxt (asm_word)
    );

`ifdef MICROCODE_LOADER_CHECKSUM_EN
    logic [15:0]           csum;
    logic [BYTE_WIDTH-1:0] exp_lo;
    logic                  csum_hi;
    logic                  error_q;
    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= LD_IDLE;
            addr          <= '0;
            last_addr     <= '0;
            mem_we_q      <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            done_q        <= 1'b0;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
            csum          <= '0;
            exp_lo        <= '0;
            csum_hi       <= 1'b0;
            error_q       <= 1'b0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state)
                LD_IDLE: begin
                    if (bus.start) begin
                        addr      <= '0;
                        last_addr <= ADDR_WIDTH'(words_clamped - 1'b1);
`ifdef MICROCODE_LOADER_CHECKSUM_EN
                        csum      <= '0;
                        csum_hi   <= 1'b0;
                        error_q   <= 1'b0;
`endif
                        state     <= (words_clamped == '0) ? LD_DONE : LD_RECV;
                    end
                end
                LD_RECV: begin
                    if (accept) begin
`ifdef MICROCODE_LOADER_CHECKSUM_EN
                        csum <= csum + 16'(bus.in_data);
`endif
                        if (asm_last) begin
                            mem_we_q      <= 1'b1;
                            mem_address_q <= addr;
                            mem_data_q    <= asm_word;
                            state         <= LD_WRITE;
                        end
                    end
                end
                LD_WRITE: begin
                    if (addr == last_addr) begin
`ifdef MICROCODE_LOADER_CHECKSUM_EN
                        state <= LD_CSUM;
`else
                        state <= LD_DONE;
`endif
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= LD_RECV;
                    end
                end
`ifdef MICROCODE_LOADER_CHECKSUM_EN
                LD_CSUM: begin
                    if (accept) begin
                        if (!csum_hi) begin
                            exp_lo  <= bus.in_data;
                            csum_hi <= 1'b1;
                        end else begin
                            error_q <= ({bus.in_data, exp_lo} != csum);
                            state   <= LD_DONE;
                        end
                    end
                end
`endif
                LD_DONE: begin
                    done_q <= 1'b1;
                    state  <= LD_IDLE;
                end
                default: state <= LD_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data    = mem_data_q;
    assign bus.busy        = (state != LD_IDLE);
    assign bus.hold_core   = (state != LD_IDLE);
    assign bus.done        = done_q;

endmodule
